uart_rx_fifo: RTL

- Parametrised successor to the fixed 8N1-style receiver.
- Self-contained 16x-oversampled UART receiver with run-time parity and stop-bit configuration, a compile-time data width, and an internal receive FIFO holding per-frame error flags.
- Replaces the pop-toggle/single-register handoff with a standard first-word-fall-through FIFO interface.
- Sits between the pad-side rx line and the bus register block; the register block runs on fclk.

---
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Receive-FIFO read/status bus between uart_rx_fifo and the fclk register block.
// master = register block (pops, clears overrun), slave = receiver.
interface uart_rx_fifo_if #(
    parameter int unsigned DBITS = 8,
    parameter int unsigned AW    = 2
);
    logic             pop;
    logic             clr_ovr;
    logic [DBITS-1:0] rdata;
    logic             perr;
    logic             ferr;
    logic             empty;
    logic             full;
    logic [AW:0]      level;
    logic             ovr;
    logic             busy;

    modport master (
        output pop, clr_ovr,
        input  rdata, perr, ferr, empty, full, level, ovr, busy
    );

    modport slave (
        input  pop, clr_ovr,
        output rdata, perr, ferr, empty, full, level, ovr, busy
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver with run-time parity/stop config and a FWFT receive FIFO.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote over phases 6/7/8, decision at phase 8.
module uart_rx_fifo #(
    parameter int unsigned CMSB  = 12,
    parameter int unsigned DBITS = 8,
    parameter int unsigned AW    = 2
) (
    input  logic              fclk,
    input  logic              rstn,
    input  logic              en,
    input  logic [CMSB:0]     div,
    input  logic              par_en,
    input  logic              par_odd,
    input  logic              stop2,
    input  logic              rx,
    uart_rx_fifo_if.slave     bus
);
    localparam int unsigned DEPTH = 2**AW;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned EW    = DBITS + 2;
    localparam int unsigned BCW   = $clog2(DBITS);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] DPH = 4'd8;
`else
    localparam logic [3:0] DPH = 4'd7;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t state, state_nx;

    logic             rx_meta, rxs, rxs_d;
    logic [CMSB:0]    cnt;
    logic [3:0]       phase;
    logic [DBITS-1:0] shreg;
    logic [BCW-1:0]   bitcnt;
    logic             perr_q, ferr_q;
    logic             busy_q;

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level_q, level_nx;
    logic             empty_q, full_q, ovr_q;
    logic [EW-1:0]    mem [DEPTH];

    logic fall_c, tick_c, samp_c, bit_c;
    logic start_c, shift_c, par_c, stop1_c, stop2_c, wr_c;
    logic ferr_wr_c, full_c, do_pop_c, do_wr_c, ovr_set_c;

    // two-flop synchroniser plus delayed copy for edge detection
    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign fall_c = rxs_d & ~rxs;
    assign tick_c = (cnt == div);
    assign samp_c = tick_c && (phase == DPH);

    // oversample tick and 16-phase counter, realigned to each start edge
    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            phase <= '0;
        end else if (start_c) begin
            cnt   <= '0;
            phase <= '0;
        end else if (tick_c) begin
            cnt   <= '0;
            phase <= phase + 4'd1;
        end else begin
            cnt   <= cnt + (CMSB+1)'(1);
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic s6, s7;

    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            s6 <= 1'b1;
            s7 <= 1'b1;
        end else if (tick_c) begin
            if (phase == 4'd6) s6 <= rxs;
            if (phase == 4'd7) s7 <= rxs;
        end
    end

    assign bit_c = (s6 & s7) | (s6 & rxs) | (s7 & rxs);
`else
    assign bit_c = rxs;
`endif

    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_q <= (state_nx != IDLE);
        end
    end

    // frame sequencing; every decision waits for the mid-bit sample tick
    always_comb begin
        state_nx = state;
        start_c  = 1'b0;
        shift_c  = 1'b0;
        par_c    = 1'b0;
        stop1_c  = 1'b0;
        stop2_c  = 1'b0;
        wr_c     = 1'b0;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fall_c) begin
                        state_nx = START;
                        start_c  = 1'b1;
                    end
                end
                START: begin
                    if (samp_c) state_nx = bit_c ? IDLE : DATA;
                end
                DATA: begin
                    if (samp_c) begin
                        shift_c = 1'b1;
                        if (bitcnt == BCW'(DBITS-1)) state_nx = par_en ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    if (samp_c) begin
                        par_c    = 1'b1;
                        state_nx = STOP1;
                    end
                end
                STOP1: begin
                    if (samp_c) begin
                        stop1_c = 1'b1;
                        if (stop2) begin
                            state_nx = STOP2;
                        end else begin
                            wr_c     = 1'b1;
                            state_nx = IDLE;
                        end
                    end
                end
                STOP2: begin
                    if (samp_c) begin
                        stop2_c  = 1'b1;
                        wr_c     = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // frame datapath: LSB-first shifter, bit count, per-frame error flags
    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            shreg  <= '0;
            bitcnt <= '0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (start_c) begin
                bitcnt <= '0;
                perr_q <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (shift_c) begin
                shreg  <= {bit_c, shreg[DBITS-1:1]};
                bitcnt <= bitcnt + BCW'(1);
            end
            if (par_c)   perr_q <= ((^shreg) ^ bit_c) != par_odd;
            if (stop1_c) ferr_q <= ~bit_c;
        end
    end

    // the last stop sample is folded in directly so the write happens on that tick
    assign ferr_wr_c = stop2_c ? (ferr_q | ~bit_c) : ~bit_c;

    assign full_c    = (level_q == LW'(DEPTH));
    assign do_pop_c  = bus.pop & (level_q != '0);
    assign do_wr_c   = wr_c & (~full_c | bus.pop);
    assign ovr_set_c = wr_c & full_c & ~bus.pop;

    always_comb begin
        level_nx = level_q;
        case ({do_wr_c, do_pop_c})
            2'b10:   level_nx = level_q + LW'(1);
            2'b01:   level_nx = level_q - LW'(1);
            default: level_nx = level_q;
        endcase
    end

    // FIFO storage, pointers and registered status
    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (do_wr_c) begin
                mem[wr_ptr] <= {ferr_wr_c, perr_q, shreg};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop_c) rd_ptr <= rd_ptr + AW'(1);
            level_q <= level_nx;
            empty_q <= (level_nx == '0);
            full_q  <= (level_nx == LW'(DEPTH));
            if (ovr_set_c)        ovr_q <= 1'b1;
            else if (bus.clr_ovr) ovr_q <= 1'b0;
        end
    end

    assign {bus.ferr, bus.perr, bus.rdata} = mem[rd_ptr];
    assign bus.empty = empty_q;
    assign bus.full  = full_q;
    assign bus.level = level_q;
    assign bus.ovr   = ovr_q;
    assign bus.busy  = busy_q;
endmodule
